// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one single-port synchronous RAM.
// Data wins contention unless fetch has been starved for STARVE_MAX cycles.
module mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              i_if_req,
    input  logic [31:0]       i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic              o_if_err,
    output logic [31:0]       o_if_rdata,

    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [3:0]        i_d_be,
    input  logic [31:0]       i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic              o_d_err,
    output logic [31:0]       o_d_rdata,

    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;

    logic own_if_q;
    logic own_d_q;
    logic err_q;
    logic rd_q;

    logic if_err;
    logic d_err;
    logic fetch_forced;
    logic if_gnt;
    logic d_gnt;
    logic gnt_err;
    logic gnt_rd;

    // Word address only; byte offset bits are deliberately ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_if_addr[1:0], i_d_addr[1:0]};

    assign if_err = |i_if_addr[31:ADDR_W+2];
    assign d_err  = |i_d_addr[31:ADDR_W+2];

    assign fetch_forced = i_if_req && (starve_cnt == CNT_MAX);

    always_comb begin
        d_gnt  = 1'b0;
        if_gnt = 1'b0;
        if (i_rst_n) begin
            d_gnt  = i_d_req && !fetch_forced;
            if_gnt = i_if_req && !d_gnt;
        end
    end

    assign o_if_gnt = if_gnt;
    assign o_d_gnt  = d_gnt;

    assign gnt_err = (d_gnt && d_err) || (if_gnt && if_err);
    assign gnt_rd  = if_gnt || (d_gnt && !i_d_we);

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_be    = 4'h0;
        o_mem_addr  = '0;
        o_mem_wdata = 32'h0;
        if (d_gnt && !d_err) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_d_we;
            o_mem_be    = i_d_be;
            o_mem_addr  = i_d_addr[ADDR_W+1:2];
            o_mem_wdata = i_d_wdata;
        end else if (if_gnt && !if_err) begin
            o_mem_en    = 1'b1;
            o_mem_be    = 4'hF;
            o_mem_addr  = i_if_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        starve_nxt = '0;
        if (i_if_req && !if_gnt) begin
            if (starve_cnt == CNT_MAX) begin
                starve_nxt = starve_cnt;
            end else begin
                starve_nxt = starve_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
            own_if_q   <= 1'b0;
            own_d_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            own_if_q   <= if_gnt;
            own_d_q    <= d_gnt;
            err_q      <= gnt_err;
            rd_q       <= gnt_rd;
        end
    end

    // Read data is only forwarded for a clean read; writes and errors return 0.
    assign o_if_rvalid = own_if_q;
    assign o_if_err    = own_if_q && err_q;
    assign o_if_rdata  = (own_if_q && rd_q && !err_q) ? i_mem_rdata : 32'h0;

    assign o_d_rvalid  = own_d_q;
    assign o_d_err     = own_d_q && err_q;
    assign o_d_rdata   = (own_d_q && rd_q && !err_q) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-enabled synchronous RAM model.
module tb_mem_arbiter;

    localparam int ADDR_W = 10;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_if_req;
    logic [31:0]       i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic              o_if_err;
    logic [31:0]       o_if_rdata;
    logic              i_d_req;
    logic              i_d_we;
    logic [3:0]        i_d_be;
    logic [31:0]       i_d_addr;
    logic [31:0]       i_d_wdata;
    logic              o_d_gnt;
    logic              o_d_rvalid;
    logic              o_d_err;
    logic [31:0]       o_d_rdata;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [3:0]        o_mem_be;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata = 32'h0;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_err    (o_if_err),
        .o_if_rdata  (o_if_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_be      (i_d_be),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .o_d_gnt     (o_d_gnt),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_err     (o_d_err),
        .o_d_rdata   (o_d_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_we    (o_mem_we),
        .o_mem_be    (o_mem_be),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_mem_en) begin
            if (o_mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (o_mem_be[b]) begin
                        mem[o_mem_addr][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
                    end
                end
            end else begin
                i_mem_rdata <= mem[o_mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_if_req  = 1'b0;
        i_if_addr = 32'h0;
        i_d_req   = 1'b0;
        i_d_we    = 1'b0;
        i_d_be    = 4'h0;
        i_d_addr  = 32'h0;
        i_d_wdata = 32'h0;
    endtask

    task automatic d_access(input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input string tag);
        i_d_req   = 1'b1;
        i_d_we    = we;
        i_d_be    = be;
        i_d_addr  = addr;
        i_d_wdata = wd;
        #1;
        check({tag, "_gnt"}, o_d_gnt, 1);
        check({tag, "_mem_we"}, o_mem_we, we);
        check({tag, "_mem_addr"}, o_mem_addr, addr[ADDR_W+1:2]);
        tick();
        check({tag, "_rvalid"}, o_d_rvalid, 1);
        check({tag, "_rdata"}, o_d_rdata, exp_rd);
        check({tag, "_err"}, o_d_err, 0);
    endtask

    logic [7:0] pat;

    initial begin
        mem[5] <= 32'h00500093;
        idle();
        i_rst_n  = 1'b0;
        i_if_req = 1'b1;
        i_d_req  = 1'b1;
        #12;
        check("rst_if_gnt", o_if_gnt, 0);
        check("rst_d_gnt", o_d_gnt, 0);
        check("rst_mem_en", o_mem_en, 0);
        check("rst_mem_be", o_mem_be, 0);
        check("rst_rvalid", {o_if_rvalid, o_d_rvalid}, 0);
        tick();
        idle();
        i_rst_n = 1'b1;
        tick();

        // fetch-only read
        i_if_req  = 1'b1;
        i_if_addr = 32'h14;
        #1;
        check("f_gnt", o_if_gnt, 1);
        check("f_d_gnt", o_d_gnt, 0);
        check("f_mem_en", o_mem_en, 1);
        check("f_mem_addr", o_mem_addr, 5);
        check("f_mem_be", o_mem_be, 4'hF);
        check("f_mem_we", o_mem_we, 0);
        tick();
        idle();
        check("f_rvalid", o_if_rvalid, 1);
        check("f_rdata", o_if_rdata, 32'h00500093);
        check("f_err", o_if_err, 0);
        check("f_d_rvalid", o_d_rvalid, 0);
        tick();
        check("f_rvalid_once", o_if_rvalid, 0);
        check("f_rdata_idle", o_if_rdata, 0);

        // back-to-back data accesses
        d_access(1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 32'h0, "wr");
        d_access(1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, "rd");
        d_access(1'b1, 4'h1, 32'h102, 32'h00000011, 32'h0, "wrb");
        d_access(1'b0, 4'hF, 32'h103, 32'h0, 32'hDEADBE11, "rdb");
        idle();
        tick();

        // out-of-range data read
        i_d_req  = 1'b1;
        i_d_addr = 32'h1000;
        #1;
        check("oor_gnt", o_d_gnt, 1);
        check("oor_mem_en", o_mem_en, 0);
        tick();
        idle();
        check("oor_rvalid", o_d_rvalid, 1);
        check("oor_err", o_d_err, 1);
        check("oor_rdata", o_d_rdata, 0);
        check("oor_if_err", o_if_err, 0);
        tick();
        check("oor_err_clr", o_d_err, 0);

        // continuous contention: fetch wins every fourth cycle
        pat       = 8'b1000_1000;
        i_if_req  = 1'b1;
        i_if_addr = 32'h14;
        i_d_req   = 1'b1;
        i_d_addr  = 32'h100;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("c%0d_if_gnt", i), o_if_gnt, pat[i]);
            check($sformatf("c%0d_d_gnt", i), o_d_gnt, !pat[i]);
            check($sformatf("c%0d_starve", i), 32'(dut.starve_cnt), i % 4);
            tick();
            check($sformatf("c%0d_if_rv", i), o_if_rvalid, pat[i]);
            check($sformatf("c%0d_d_rv", i), o_d_rvalid, !pat[i]);
            if (pat[i]) begin
                check($sformatf("c%0d_if_rd", i), o_if_rdata, 32'h00500093);
            end else begin
                check($sformatf("c%0d_d_rd", i), o_d_rdata, 32'hDEADBE11);
            end
        end

        // fetch withdraws after losing: starvation state clears
        i_if_req = 1'b0;
        tick();
        check("wd_starve", 32'(dut.starve_cnt), 0);
        idle();
        #1;
        check("idle_mem_en", o_mem_en, 0);
        tick();
        check("idle_starve", 32'(dut.starve_cnt), 0);
        check("idle_rvalid", {o_if_rvalid, o_d_rvalid}, 0);

        // reset lands inside a fetch grant cycle
        i_if_req  = 1'b1;
        i_if_addr = 32'h14;
        #1;
        check("rm_gnt", o_if_gnt, 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rm_gnt_rst", o_if_gnt, 0);
        check("rm_mem_en", o_mem_en, 0);
        check("rm_mem_addr", o_mem_addr, 0);
        tick();
        check("rm_rvalid", o_if_rvalid, 0);
        idle();
        i_rst_n = 1'b1;
        tick();
        check("rm_rvalid_post", o_if_rvalid, 0);
        check("rm_rdata_post", o_if_rdata, 0);

        // fresh fetch after release
        i_if_req  = 1'b1;
        i_if_addr = 32'h14;
        #1;
        check("rf_gnt", o_if_gnt, 1);
        tick();
        idle();
        check("rf_rvalid", o_if_rvalid, 1);
        check("rf_rdata", o_if_rdata, 32'h00500093);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the memory word-address width (1024 words).
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning the consecutive fetch-loss cycles before fetch is forced to win.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have ports i_if_req / i_if_addr, input, 1 / 32, instruction-fetch request and byte address.
REQ-006 SHALL have ports o_if_gnt / o_if_rvalid / o_if_err, output, 1 each, fetch grant, read-data valid and address error.
REQ-007 SHALL have port o_if_rdata, output, 32, fetch read data.
REQ-008 SHALL have inputs i_d_req, i_d_we, i_d_be, i_d_addr, i_d_wdata, widths 1, 1, 4, 32, 32, data request, write enable, byte enables, byte address and write data.
REQ-009 SHALL have port o_d_gnt / o_d_rvalid / o_d_err, output, 1 each, data grant, completion and address error.
REQ-010 SHALL have port o_d_rdata, output, 32, data read data.
REQ-011 SHALL have outputs o_mem_en, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata, widths 1, 1, 4, ADDR_W, 32, driving the single-port synchronous memory.
REQ-012 SHALL have port i_mem_rdata, input, 32, memory read data, valid one cycle after o_mem_en with o_mem_we low.

Function
REQ-013 SHALL grant at most one requester per cycle; o_*_gnt is combinational from the requests and the registered arbitration state.
REQ-014 SHALL implement the request handshake as follows: a request is accepted in the cycle where req and gnt are both high, and the requester holds its addr, we, be and wdata stable until that cycle.
REQ-015 SHALL give the data port priority when both ports request, unless starve_cnt equals STARVE_MAX, in which case fetch wins.
REQ-016 SHALL update starve_cnt each cycle as follows: +1 when i_if_req is high and fetch is not granted, saturating at STARVE_MAX; cleared to 0 when fetch is granted or i_if_req is low.
REQ-017 SHALL drive o_mem_en high in the grant cycle for an in-range address, with o_mem_addr set to addr[ADDR_W+1:2]; o_mem_we, be and wdata come from the data port when data is granted, and are 0 and 4'hF for fetch.
REQ-018 SHALL treat an address as out of range when addr[31:ADDR_W+2] is nonzero; an out-of-range grant SHALL hold o_mem_en low and produce no memory access.
REQ-019 SHALL ignore addr[1:0], which is not checked.
REQ-020 SHALL register the owner and the error of each grant; in the cycle after a grant, the granted port's o_*_rvalid is high for exactly one cycle.
REQ-021 SHALL drive o_*_rdata to i_mem_rdata when rvalid is high for an in-range read, and to 32'h0 for writes, errors and non-rvalid cycles.
REQ-022 SHALL drive o_*_err equal to the registered error, high only together with rvalid.
REQ-023 SHALL signal data-write completion by the o_d_rvalid pulse.
REQ-024 SHALL allow back-to-back grants every cycle, with a throughput of 1 access per cycle and a read latency of 1 cycle.
REQ-025 SHALL allow the grant and the previous rvalid to the same or the other port in the same cycle.
REQ-026 SHALL treat a request deasserted before its grant as withdrawn, leaving no state behind.
REQ-027 SHALL take no action when there are no requests: o_mem_en low, starve_cnt 0.

Reset
REQ-028 SHALL, on i_rst_n low, asynchronously clear starve_cnt, the owner register, the error register and both rvalid/err outputs to 0.
REQ-029 SHALL hold all outputs at 0 while i_rst_n is low, including o_*_gnt and o_mem_en.
REQ-030 SHALL discard a read in flight when reset asserts mid-operation: no rvalid after release.
REQ-031 SHALL allow the first grant in the first clock edge after i_rst_n rises.

Verification
REQ-032 SHALL cover a fetch-only read: memory word 5 = 32'h00500093, i_if_addr=32'h14, expect o_if_gnt=1, o_mem_addr=5, o_mem_en=1, then next cycle o_if_rvalid=1 and o_if_rdata=32'h00500093.
REQ-033 SHALL cover a data write then read: write 32'hDEADBEEF with be=4'hF at 32'h100, then read 32'h100, expect o_d_rvalid pulses on both with o_d_rdata=0 then 32'hDEADBEEF; a be=4'h1 write of 32'h11 then gives 32'hDEADBE11.
REQ-034 SHALL cover contention with both ports requesting continuously: the grant pattern is D,D,D,I,D,D,D,I, with starve_cnt 0,1,2,3,0.
REQ-035 SHALL cover an out-of-range access: i_d_addr=32'h1000 (ADDR_W=10), expect o_mem_en=0, and next cycle o_d_rvalid=1, o_d_err=1, o_d_rdata=0.
REQ-036 SHALL cover reset mid-read: assert i_rst_n low between the grant and the rvalid edge, expect o_if_rvalid to stay 0 and all outputs 0 immediately; after release, a fresh fetch completes normally.
